// File: rtl/mem_lsu_if.sv
// Request/response and RAM-port bundle for the load/store unit.
// The slave modport is the LSU; master is the core + RAM side.
interface mem_lsu_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_split;
    logic            mem_rd_ena;
    logic            mem_wr_ena;
    logic [7:0]      byte_enable;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wr_data;
    logic [XLEN-1:0] mem_rd_data;

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_split,
        output mem_rd_ena, mem_wr_ena, byte_enable, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_split,
        input  mem_rd_ena, mem_wr_ena, byte_enable, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator: turns byte-addressed core requests into dword-aligned,
// byte-masked RAM beats, splitting accesses that straddle a dword boundary.
module mem_lsu #(
    parameter int XLEN = 64
) (
    input logic      clk,
    input logic      rst_n,
    mem_lsu_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state;
    logic            c_wen;
    logic [1:0]      c_size;
    logic            c_uns;
    logic [XLEN-1:0] c_addr;
    logic [XLEN-1:0] c_wdata;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;

    logic [2:0]        off;
    logic [3:0]        nbytes;
    logic [15:0]       mask16;
    logic [6:0]        shamt;
    logic [2*XLEN-1:0] wide_wdata;
    logic              split;
    logic [XLEN-1:0]   hi_eff;
    logic [XLEN-1:0]   ld_raw;
    logic [XLEN-1:0]   ld_ext;
    logic [XLEN-1:0]   a0;

    assign off        = c_addr[2:0];
    assign nbytes     = 4'd1 << c_size;
    assign mask16     = ((16'd1 << nbytes) - 16'd1) << off;
    assign shamt      = {1'b0, off, 3'b000};
    assign wide_wdata = {{XLEN{1'b0}}, c_wdata} << shamt;
    assign split      = ({1'b0, off} + nbytes) > 4'd8;
    assign a0         = {c_addr[XLEN-1:3], 3'b000};

    // hi is stale on non-split loads, so it must not leak into the result
    assign hi_eff = split ? hi : '0;
    assign ld_raw = XLEN'({hi_eff, lo} >> shamt);

    always_comb begin
        ld_ext = ld_raw;
        case (c_size)
            2'd0: ld_ext = {{(XLEN-8){~c_uns & ld_raw[7]}}, ld_raw[7:0]};
            2'd1: ld_ext = {{(XLEN-16){~c_uns & ld_raw[15]}}, ld_raw[15:0]};
            2'd2: ld_ext = {{(XLEN-32){~c_uns & ld_raw[31]}}, ld_raw[31:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_split  = 1'b0;
        bus.mem_rd_ena  = 1'b0;
        bus.mem_wr_ena  = 1'b0;
        bus.byte_enable = '0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        case (state)
            BEAT0: begin
                bus.mem_addr    = a0;
                bus.byte_enable = mask16[7:0];
                bus.mem_wr_data = wide_wdata[XLEN-1:0];
                bus.mem_rd_ena  = ~c_wen;
                bus.mem_wr_ena  = c_wen;
            end
            BEAT1: begin
                bus.mem_addr    = a0 + XLEN'(8);
                bus.byte_enable = mask16[15:8];
                bus.mem_wr_data = wide_wdata[2*XLEN-1:XLEN];
                bus.mem_rd_ena  = ~c_wen;
                bus.mem_wr_ena  = c_wen;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = c_wen ? '0 : ld_ext;
                bus.resp_split = split;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            c_wen   <= 1'b0;
            c_size  <= '0;
            c_uns   <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            lo      <= '0;
            hi      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    c_wen   <= bus.req_wen;
                    c_size  <= bus.req_size;
                    c_uns   <= bus.req_unsigned;
                    c_addr  <= bus.req_addr;
                    c_wdata <= bus.req_wdata;
                    state   <= BEAT0;
                end
                BEAT0: begin
                    if (!c_wen) lo <= bus.mem_rd_data;
                    state <= split ? BEAT1 : RESP;
                end
                BEAT1: begin
                    if (!c_wen) hi <= bus.mem_rd_data;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
